// File: rtl/regfile_mp_pkg.sv
// Shared constants and state encoding for the multi-port register file.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_mp_pkg;

   localparam int WORD_LEN    = 32;
   localparam int REGADDR_LEN = 5;
   localparam int RF_DEPTH    = 32;
   localparam int RF_NRD      = 2;
   localparam int RF_NWR      = 2;

   typedef enum logic {
      RF_ST_IDLE  = 1'b0,
      RF_ST_CLEAR = 1'b1
   } rf_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks cnt over every entry after reset or clr_req,
// and gates writes/reads via ready until the walk completes.
module regfile_clr_fsm
   import regfile_mp_pkg::*;
#(
   parameter int AW    = REGADDR_LEN,
   parameter int DEPTH = RF_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          idle,
   output logic          ready,
   output logic          clr_done,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   rf_state_t     state, state_nx;
   logic [AW-1:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RF_ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ready    = 1'b0;
      clr_done = 1'b0;
      clr_we   = 1'b0;
      case (state)
         RF_ST_IDLE: begin
            ready = !rst;
            if (clr_req) begin
               state_nx = RF_ST_CLEAR;
               cnt_nx   = '0;
            end
         end
         RF_ST_CLEAR: begin
            clr_we = 1'b1;
            cnt_nx = cnt + 1'b1;
            // final entry: hand back to IDLE and pulse done in this same cycle
            if (cnt == LAST) begin
               state_nx = RF_ST_IDLE;
               clr_done = !rst;
            end
         end
         default: state_nx = RF_ST_CLEAR;
      endcase
   end

   assign idle     = (state == RF_ST_IDLE);
   assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS32 GPR file: NRD async read ports, NWR sync write ports, r0 = 0.
// Build macro REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int W     = WORD_LEN,
   parameter int AW    = REGADDR_LEN,
   parameter int DEPTH = RF_DEPTH,
   parameter int NRD   = RF_NRD,
   parameter int NWR   = RF_NWR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   input  logic [NWR-1:0]    w_en,
   input  logic [NWR*AW-1:0] w_addr,
   input  logic [NWR*W-1:0]  w_data,
   input  logic [NRD*AW-1:0] r_addr,
   output logic [NRD*W-1:0]  r_data,
   output logic              ready,
   output logic              clr_done
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic          idle;
   logic          clr_we;
   logic [AW-1:0] clr_addr;
   logic [W-1:0]  regs [DEPTH];

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && ({1'b0, a} < DEPTH_W);
   endfunction

   regfile_clr_fsm #(.AW(AW), .DEPTH(DEPTH)) u_clr (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .idle     (idle),
      .ready    (ready),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // Ascending port loop: the last NBA to an address wins, i.e. highest port index.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         regs[clr_addr] <= '0;
      end else if (ready) begin
         for (int k = 0; k < NWR; k++) begin
            if (w_en[k] && addr_ok(w_addr[k*AW +: AW]))
               regs[w_addr[k*AW +: AW]] <= w_data[k*W +: W];
         end
      end
   end

   for (genvar j = 0; j < NRD; j++) begin : g_rd
      logic [AW-1:0] ra;
      logic [W-1:0]  rd;

      assign ra = r_addr[j*AW +: AW];

      always_comb begin
         rd = '0;
         if (idle && addr_ok(ra)) begin
            rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
               if (ready && w_en[k] && (w_addr[k*AW +: AW] == ra))
                  rd = w_data[k*W +: W];
            end
`endif
         end
      end

      assign r_data[j*W +: W] = rd;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expectations from a
// cycle-count reference model; a negedge monitor pops and compares.
module tb_regfile_mp;

   localparam int W = 32, AW = 5, DEPTH = 32, NRD = 2, NWR = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clr_req = 1'b0;
   logic [NWR-1:0]    w_en = '0;
   logic [NWR*AW-1:0] w_addr = '0;
   logic [NWR*W-1:0]  w_data = '0;
   logic [NRD*AW-1:0] r_addr = '0;
   logic [NRD*W-1:0]  r_data;
   logic              ready, clr_done;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .rst(rst), .clr_req(clr_req), .w_en(w_en), .w_addr(w_addr),
      .w_data(w_data), .r_addr(r_addr), .r_data(r_data), .ready(ready), .clr_done(clr_done)
   );

   typedef struct {
      bit                     chk_ctl;
      bit                     chk_rd;
      bit                     rdy;
      bit                     done;
      logic [NRD-1:0][W-1:0]  rd;
      int                     cyc;
   } exp_t;

   exp_t        sbq[$];
   exp_t        me;
   logic [W-1:0] mdl [DEPTH];
   int          clr_left = 0;   // cycles of clearing still to run, 0 = idle
   bit          st_known = 0;
   bit          mem_known = 0;
   int          checks = 0, failures = 0, ncyc = 0;

   function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit rdy,
                                           input logic [NWR-1:0] we,
                                           input logic [NWR-1:0][AW-1:0] wa,
                                           input logic [NWR-1:0][W-1:0] wd);
      logic [W-1:0] v;
      if (clr_left != 0 || a == 0 || int'(a) >= DEPTH) return '0;
      v = mdl[a];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++)
         if (rdy && we[k] && wa[k] == a) v = wd[k];
`endif
      return v;
   endfunction

   task automatic cyc(input bit r, input bit cr, input logic [NWR-1:0] we,
                      input logic [NWR-1:0][AW-1:0] wa, input logic [NWR-1:0][W-1:0] wd,
                      input logic [NRD-1:0][AW-1:0] ra);
      exp_t e;
      @(posedge clk); #1;
      rst = r; clr_req = cr; w_en = we; w_addr = wa; w_data = wd; r_addr = ra;
      e.cyc     = ncyc++;
      e.chk_ctl = st_known;
      e.chk_rd  = st_known && (mem_known || clr_left != 0);
      e.rdy     = (clr_left == 0) && !r;
      e.done    = (clr_left == 1) && !r;
      for (int j = 0; j < NRD; j++) e.rd[j] = exp_rd(ra[j], e.rdy, we, wa, wd);
      sbq.push_back(e);
      // advance the model across the coming edge
      if (r) begin
         clr_left = DEPTH;
         st_known = 1;
      end else if (clr_left > 0) begin
         clr_left--;
         if (clr_left == 0) begin
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            mem_known = 1;
         end
      end else begin
         for (int k = 0; k < NWR; k++)
            if (we[k] && wa[k] != 0 && int'(wa[k]) < DEPTH) mdl[wa[k]] = wd[k];
         if (cr) clr_left = DEPTH;
      end
   endtask

   task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      cyc(0, 0, '0, '0, '0, {a1, a0});
   endtask

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp, input int c);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            me = sbq.pop_front();
            if (me.chk_ctl) begin
               check("ready", W'(ready), W'(me.rdy), me.cyc);
               check("clr_done", W'(clr_done), W'(me.done), me.cyc);
            end
            if (me.chk_rd)
               for (int j = 0; j < NRD; j++)
                  check($sformatf("r_data%0d", j), r_data[j*W +: W], me.rd[j], me.cyc);
         end
      end
   end

   initial begin
      logic [NWR-1:0][AW-1:0] wa;
      logic [NWR-1:0][W-1:0]  wd;
      logic [NRD-1:0][AW-1:0] ra;
      // reset + full clear, reads at every address along the way
      cyc(1, 0, '0, '0, '0, '0);
      for (int i = 0; i < 36; i++) rd2(AW'(i), AW'(31 - i));
      // single write, then write to r0
      cyc(0, 0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, {5'd0, 5'd5});
      rd2(5, 0);
      cyc(0, 0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234}, {5'd5, 5'd0});
      rd2(0, 5);
      // same-address collision: port1 must win
      cyc(0, 0, 2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, {5'd7, 5'd5});
      rd2(7, 7);
      // clr_req after r9 write; second clr_req mid-clear is ignored
      cyc(0, 0, 2'b01, {5'd0, 5'd9}, {32'h0, 32'hFF}, {5'd9, 5'd9});
      cyc(0, 1, '0, '0, '0, {5'd9, 5'd7});
      for (int i = 0; i < 34; i++) cyc(0, (i == 15), '0, '0, '0, {5'd9, 5'd7});
      // rst at cnt=10; writes during clear are dropped
      cyc(0, 0, 2'b10, {5'd3, 5'd0}, {32'h77, 32'h0}, {5'd3, 5'd3});
      cyc(0, 1, '0, '0, '0, '0);
      for (int i = 0; i < 10; i++) rd2(3, 3);
      cyc(1, 0, '0, '0, '0, '0);
      for (int i = 0; i < 34; i++) cyc(0, 0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h33}, {5'd3, 5'd4});
      rd2(3, 3);
      // same-cycle write/read of r4
      cyc(0, 0, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h1}, {5'd4, 5'd4});
      cyc(0, 0, 2'b01, {5'd0, 5'd4}, {32'h0, 32'hA5}, {5'd4, 5'd4});
      rd2(4, 4);
      // randomized traffic over a small address window to force collisions
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NWR; k++) begin
            wa[k] = AW'($urandom_range(0, 9));
            wd[k] = $urandom;
         end
         for (int j = 0; j < NRD; j++)
            ra[j] = ($urandom_range(0, 2) == 0) ? wa[j % NWR] : AW'($urandom_range(0, 31));
         cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0),
             NWR'($urandom), wa, wd, ra);
      end
      rd2(0, 0);
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (sbq.size() > 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
